// File: rtl/usb_warmboot_ctrl.sv
// Warm-boot sequencer for the iCE40 SB_WARMBOOT primitive: watches SOF activity,
// accepts explicit boot requests, and drives S1/S0 stable for a setup window before BOOT.
module usb_warmboot_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 48000000,
    parameter int unsigned SETUP_CYCLES   = 16,
    parameter logic [1:0]  DEFAULT_IMAGE  = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sof_valid,
    input  logic [10:0] frame_index,
    input  logic        boot_req,
    input  logic [1:0]  boot_image,
    output logic        boot_ack,
    output logic        host_present,
    output logic [10:0] last_frame,
    output logic        busy,
    output logic        warmboot_s1,
    output logic        warmboot_s0,
    output logic        warmboot_boot
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [SW-1:0] SETUP_LAST = SW'(SETUP_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_HOST   = 2'd0,
        HOST_ACTIVE = 2'd1,
        SETUP       = 2'd2,
        BOOT        = 2'd3
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [SW-1:0] setup_cnt;
    logic [1:0]    image;
    logic          timeout;

    // A SOF arriving on the last idle cycle keeps the host alive.
    assign timeout = (timer == TIMER_LAST) && !sof_valid;

    // sof_valid and boot_req are sampled on every edge with no back-pressure; a request
    // is taken only while listening, and boot_ack pulses for one cycle on the edge that
    // takes it, so a request held high is acknowledged exactly once.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= WAIT_HOST;
            timer         <= '0;
            setup_cnt     <= '0;
            image         <= DEFAULT_IMAGE;
            boot_ack      <= 1'b0;
            host_present  <= 1'b0;
            last_frame    <= '0;
            busy          <= 1'b0;
            warmboot_s1   <= DEFAULT_IMAGE[1];
            warmboot_s0   <= DEFAULT_IMAGE[0];
            warmboot_boot <= 1'b0;
        end else begin
            boot_ack <= 1'b0;
            case (state)
                WAIT_HOST, HOST_ACTIVE: begin
                    if (sof_valid) begin
                        timer        <= '0;
                        last_frame   <= frame_index;
                        host_present <= 1'b1;
                    end else if (timer != TIMER_MAX) begin
                        timer <= timer + 1'b1;
                    end

                    if (boot_req) begin
                        image                      <= boot_image;
                        {warmboot_s1, warmboot_s0} <= boot_image;
                        boot_ack                   <= 1'b1;
                        busy                       <= 1'b1;
                        setup_cnt                  <= '0;
                        state                      <= SETUP;
                    end else if (timeout) begin
                        image                      <= DEFAULT_IMAGE;
                        {warmboot_s1, warmboot_s0} <= DEFAULT_IMAGE;
                        host_present               <= 1'b0;
                        busy                       <= 1'b1;
                        setup_cnt                  <= '0;
                        state                      <= SETUP;
                    end else if (sof_valid) begin
                        state <= HOST_ACTIVE;
                    end
                end

                SETUP: begin
                    {warmboot_s1, warmboot_s0} <= image;
                    if (setup_cnt == SETUP_LAST) begin
                        warmboot_boot <= 1'b1;
                        state         <= BOOT;
                    end else begin
                        setup_cnt <= setup_cnt + 1'b1;
                    end
                end

                BOOT: begin
                    // Terminal: the fabric is being reconfigured, only reset leaves here.
                    warmboot_boot <= 1'b1;
                    busy          <= 1'b1;
                end

                default: state <= WAIT_HOST;
            endcase
        end
    end

endmodule
